// File: rtl/window_reader.sv
// Reader side of the padded-row register stage.
// Captures one triple of padded RGB rows and streams its 3x3 sliding windows,
// left to right, over a valid/ready interface. Tracks output rows per frame
// and flags the last window of each row and of each frame.
module window_reader #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned PAD_W    = 418,
  parameter int unsigned OUT_ROWS = 416
) (
  input  logic                   clk,
  input  logic                   rst_n,

  // Row-triple load interface
  input  logic                   rows_valid,
  output logic                   rows_ready,
  input  logic [PAD_W*PIX_W-1:0] R_row0,
  input  logic [PAD_W*PIX_W-1:0] R_row1,
  input  logic [PAD_W*PIX_W-1:0] R_row2,
  input  logic [PAD_W*PIX_W-1:0] G_row0,
  input  logic [PAD_W*PIX_W-1:0] G_row1,
  input  logic [PAD_W*PIX_W-1:0] G_row2,
  input  logic [PAD_W*PIX_W-1:0] B_row0,
  input  logic [PAD_W*PIX_W-1:0] B_row1,
  input  logic [PAD_W*PIX_W-1:0] B_row2,

  // Window output interface
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [9*PIX_W-1:0]     R_win,
  output logic [9*PIX_W-1:0]     G_win,
  output logic [9*PIX_W-1:0]     B_win,
  output logic [8:0]             win_col,
  output logic                   win_last,
  output logic                   frame_last,
  output logic [8:0]             row_cnt
);

  localparam int unsigned OUT_COLS = PAD_W - 2;
  localparam int unsigned RowW     = PAD_W * PIX_W;
  localparam int unsigned WinW     = 9 * PIX_W;

  localparam logic [8:0] LastCol = 9'(OUT_COLS - 1);
  localparam logic [8:0] LastRow = 9'(OUT_ROWS - 1);

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } state_e;

  state_e state;

  // Shadow copies of the accepted triple; only written on the load handshake
  logic [RowW-1:0] r_sh [3];
  logic [RowW-1:0] g_sh [3];
  logic [RowW-1:0] b_sh [3];

  // Gather the 3x3 window whose left column is col; element (r,k) at slot r*3+k
  function automatic logic [WinW-1:0] build_win(
    input logic [RowW-1:0] row0,
    input logic [RowW-1:0] row1,
    input logic [RowW-1:0] row2,
    input int unsigned     col
  );
    logic [WinW-1:0] w;
    logic [RowW-1:0] rows [3];
    rows[0] = row0;
    rows[1] = row1;
    rows[2] = row2;
    w = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned k = 0; k < 3; k++) begin
        w[(r * 3 + k) * PIX_W +: PIX_W] = rows[r][(col + k) * PIX_W +: PIX_W];
      end
    end
    return w;
  endfunction

  // Control FSM with registered window outputs, flags and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      rows_ready <= 1'b0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      frame_last <= 1'b0;
      win_col    <= '0;
      row_cnt    <= '0;
      R_win      <= '0;
      G_win      <= '0;
      B_win      <= '0;
      for (int i = 0; i < 3; i++) begin
        r_sh[i] <= '0;
        g_sh[i] <= '0;
        b_sh[i] <= '0;
      end
    end else begin
      unique case (state)
        StIdle: begin
          if (rows_valid && rows_ready) begin
            r_sh[0]    <= R_row0;
            r_sh[1]    <= R_row1;
            r_sh[2]    <= R_row2;
            g_sh[0]    <= G_row0;
            g_sh[1]    <= G_row1;
            g_sh[2]    <= G_row2;
            b_sh[0]    <= B_row0;
            b_sh[1]    <= B_row1;
            b_sh[2]    <= B_row2;
            // First window comes straight from the buses so it is valid next cycle
            R_win      <= build_win(R_row0, R_row1, R_row2, 32'd0);
            G_win      <= build_win(G_row0, G_row1, G_row2, 32'd0);
            B_win      <= build_win(B_row0, B_row1, B_row2, 32'd0);
            win_col    <= '0;
            win_valid  <= 1'b1;
            win_last   <= (LastCol == '0);
            frame_last <= (LastCol == '0) && (row_cnt == LastRow);
            rows_ready <= 1'b0;
            state      <= StStream;
          end else begin
            rows_ready <= 1'b1;
          end
        end

        StStream: begin
          if (win_ready) begin
            if (win_col == LastCol) begin
              // Triple exhausted: drop valid, reopen the load side, count the row
              state      <= StIdle;
              win_valid  <= 1'b0;
              win_last   <= 1'b0;
              frame_last <= 1'b0;
              rows_ready <= 1'b1;
              row_cnt    <= (row_cnt == LastRow) ? '0 : row_cnt + 9'd1;
            end else begin
              win_col    <= win_col + 9'd1;
              R_win      <= build_win(r_sh[0], r_sh[1], r_sh[2], 32'(win_col) + 32'd1);
              G_win      <= build_win(g_sh[0], g_sh[1], g_sh[2], 32'(win_col) + 32'd1);
              B_win      <= build_win(b_sh[0], b_sh[1], b_sh[2], 32'(win_col) + 32'd1);
              win_last   <= ((win_col + 9'd1) == LastCol);
              frame_last <= ((win_col + 9'd1) == LastCol) && (row_cnt == LastRow);
            end
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule
